complex_mean_square_gen2: RTL
=============================

# complex_mean_square_gen2

Parametrised second-generation complex mean-square unit for the CMS datapath. It accepts a window of 2^L complex sample pairs (y, ŷ) over a ready/valid stream and forms the error e = y − ŷ. It accumulates either the complex square e² or the magnitude square |e|² in an internal multiplier pipeline, then divides by 2^L. The result is presented on a ready/valid output port. The block replaces the first-generation unit by adding parametric width and depth, selectable mode, input/output backpressure, config checking and optional rounding.

## Interface
Parameters:
- DW, 16: width of each real/imag input component (signed two's complement).
- MAX_LOG2, 8: largest supported window exponent (max 2^MAX_LOG2 samples).
- MUL_LAT, 3: multiplier pipeline depth in cycles (≥1).
- Derived, not overridable: LW = $clog2(MAX_LOG2+1); OW = 2·DW+2; ACC_W = OW+MAX_LOG2.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  begin a window; sampled only in IDLE.
- i_log2_samples  in  LW  window exponent L; latched on accepted i_start.
- i_mode  in  1  0 = complex square e², 1 = magnitude square |e|²; latched on accepted i_start.
- i_valid  in  1  input sample valid.
- o_ready  out  1  input sample accept.
- i_y  in  2·DW  {re[2DW-1:DW], im[DW-1:0]}.
- i_y_hat  in  2·DW  same packing.
- o_valid  out  1  result valid.
- i_ready  in  1  result accept.
- o_data  out  2·OW  {re[2OW-1:OW], im[OW-1:0]}, signed.
- o_busy  out  1  high in every state except IDLE.
- o_cfg_err  out  1  one-cycle pulse: i_start in IDLE with L > MAX_LOG2.

## Operation
- States: IDLE, ACCUM, DRAIN, DIVIDE, HOLD.
- IDLE → ACCUM on i_start with L ≤ MAX_LOG2. This clears the accumulators, rx_cnt and proc_cnt, and latches L and mode.
- IDLE stays in IDLE on i_start with L > MAX_LOG2, and pulses o_cfg_err. i_start in any other state is ignored.
- ACCUM: o_ready = 1 while rx_cnt < 2^L. A sample is accepted when i_valid && o_ready; rx_cnt increments on each accept. The edge that brings rx_cnt to 2^L moves the FSM to DRAIN, with o_ready low from that point.
- Datapath per accepted sample:
  - a = re(y)−re(ŷ), b = im(y)−im(ŷ), both DW+1 bits signed.
  - Pipeline computes a·a, b·b and a·b over MUL_LAT stages, with a valid shift register.
  - Mode 0: re += a²−b², im += 2ab.
  - Mode 1: re += a²+b², im += 0.
  - Both accumulators are ACC_W bits signed. proc_cnt increments on every pipeline-output valid.
- DRAIN → DIVIDE when proc_cnt == 2^L.
- DIVIDE: each component is arithmetically shifted right by L (see Configuration), truncated to OW bits and written to o_data. o_valid is set and the FSM goes to HOLD.
  - The result always fits OW bits, because |mean| ≤ 2^(2DW+1).
- HOLD: o_valid and o_data are held until i_ready. On the handshake edge o_valid drops and the FSM returns to IDLE.
- o_data keeps the last result after the handshake, until the next DIVIDE.

## Timing
- Reset (i_rst_n low at an edge), from any state including mid-window:
  - FSM goes to IDLE.
  - o_valid, o_ready, o_busy, o_cfg_err = 0; o_data = 0.
  - Accumulators, counters and pipeline valids cleared; in-flight samples discarded.
- o_ready rises one edge after the accepted i_start.
- Last sample accepted at edge k:
  - Final accumulate at edge k+MUL_LAT.
  - DIVIDE entered at k+MUL_LAT+1.
  - o_valid high after edge k+MUL_LAT+2.
- L = 0: a single sample; same latency rule, no shift.
- i_valid gaps: no effect other than added latency. Throughput is one sample per cycle.
- i_ready already high when o_valid rises: result held exactly one cycle. The next i_start is accepted one cycle later, in IDLE.

## Configuration
- CMS_ROUND_EN defined: for L > 0, 2^(L−1) is added to each component before the shift (round half up).
- CMS_ROUND_EN undefined: plain arithmetic shift (floor).
- Latency is identical in both builds.

## Test plan
- Defaults, L=2, mode 0, 4 × (y=(3,4), ŷ=(0,0)) → o_data = (−7, 24); o_valid exactly MUL_LAT+2 edges after the 4th accept.
- Same stimulus, mode 1 → (25, 0).
- L=1, mode 0, e=(0,1) then (0,0); re sum = −1 → re = −1 without CMS_ROUND_EN, 0 with it. Mode 1, e=(1,0),(0,0) → re = 0 without the macro, 1 with it.
- L=8, mode 1, 256 × (y=(−32768,−32768), ŷ=(32767,32767)) → re = 8589672450, im = 0. Mode 0 → (0, 8589672450). No overflow.
- Backpressure:
  - Random i_valid gaps; i_ready low for 5 cycles after o_valid → o_valid and o_data stable throughout.
  - i_start during HOLD ignored.
  - FSM returns to IDLE after the handshake.
- Error and reset:
  - i_start with L=9 → one-cycle o_cfg_err, o_busy stays 0.
  - i_rst_n low after 3 accepted samples → all outputs 0 at the next edge.
  - A fresh L=0 window afterwards gives the correct result.

Source files
------------

// File: rtl/complex_mean_square_gen2.sv
// Complex mean-square unit: accumulates e^2 or |e|^2 over 2^L samples (e = y - y_hat) and divides by 2^L.
// Optional build macro CMS_ROUND_EN adds round-half-up before the final shift.
module complex_mean_square_gen2 #(
  parameter  int DW       = 16,
  parameter  int MAX_LOG2 = 8,
  parameter  int MUL_LAT  = 3,
  localparam int LW       = $clog2(MAX_LOG2 + 1),
  localparam int OW       = 2 * DW + 2,
  localparam int ACC_W    = OW + MAX_LOG2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [LW-1:0]     i_log2_samples,
  input  logic              i_mode,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2*DW-1:0]   i_y,
  input  logic [2*DW-1:0]   i_y_hat,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [2*OW-1:0]   o_data,
  output logic              o_busy,
  output logic              o_cfg_err
);

  localparam int CW = MAX_LOG2 + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCUM  = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] DIVIDE = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [LW-1:0]           l_q, l_d;
  logic                    mode_q, mode_d;
  logic [CW-1:0]           rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]           proc_cnt_q, proc_cnt_d;
  logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
  logic                    o_valid_q, o_valid_d;
  logic [2*OW-1:0]         o_data_q, o_data_d;
  logic                    cfg_err_q, cfg_err_d;

  logic signed [OW-1:0]    aa_q [MUL_LAT];
  logic signed [OW-1:0]    bb_q [MUL_LAT];
  logic signed [OW-1:0]    ab_q [MUL_LAT];
  logic signed [OW-1:0]    aa_d [MUL_LAT];
  logic signed [OW-1:0]    bb_d [MUL_LAT];
  logic signed [OW-1:0]    ab_d [MUL_LAT];
  logic [MUL_LAT-1:0]      vld_q, vld_d;

  logic signed [DW:0]      err_a, err_b;
  logic [CW-1:0]           win;
  logic                    accept;
  logic signed [ACC_W-1:0] re_term, im_term;
  logic signed [ACC_W:0]   rnd_re, rnd_im, round_bias;

  assign win       = CW'(1) << l_q;
  assign o_ready   = (state_q == ACCUM) && (rx_cnt_q < win);
  assign accept    = o_ready && i_valid;
  assign o_busy    = (state_q != IDLE);
  assign o_valid   = o_valid_q;
  assign o_data    = o_data_q;
  assign o_cfg_err = cfg_err_q;

  // Error components, widened by one bit so the subtraction cannot wrap.
  assign err_a = $signed({i_y[2*DW-1], i_y[2*DW-1:DW]}) - $signed({i_y_hat[2*DW-1], i_y_hat[2*DW-1:DW]});
  assign err_b = $signed({i_y[DW-1], i_y[DW-1:0]})      - $signed({i_y_hat[DW-1], i_y_hat[DW-1:0]});

  always_comb begin
    aa_d[0]  = OW'(err_a * err_a);
    bb_d[0]  = OW'(err_b * err_b);
    ab_d[0]  = OW'(err_a * err_b);
    vld_d[0] = accept;
    for (int i = 1; i < MUL_LAT; i++) begin
      aa_d[i]  = aa_q[i-1];
      bb_d[i]  = bb_q[i-1];
      ab_d[i]  = ab_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    if (mode_q) begin
      re_term = ACC_W'(aa_q[MUL_LAT-1]) + ACC_W'(bb_q[MUL_LAT-1]);
      im_term = '0;
    end else begin
      re_term = ACC_W'(aa_q[MUL_LAT-1]) - ACC_W'(bb_q[MUL_LAT-1]);
      im_term = ACC_W'(ab_q[MUL_LAT-1]) + ACC_W'(ab_q[MUL_LAT-1]);
    end
  end

  always_comb begin
    round_bias = '0;
`ifdef CMS_ROUND_EN
    if (l_q != '0) round_bias[l_q - 1'b1] = 1'b1;
`endif
    rnd_re = (ACC_W + 1)'(acc_re_q) + round_bias;
    rnd_im = (ACC_W + 1)'(acc_im_q) + round_bias;
  end

  // NOTE: every variable gets its default first, so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    l_d        = l_q;
    mode_d     = mode_q;
    rx_cnt_d   = rx_cnt_q;
    proc_cnt_d = proc_cnt_q;
    acc_re_d   = acc_re_q;
    acc_im_d   = acc_im_q;
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    cfg_err_d  = 1'b0;

    if (vld_q[MUL_LAT-1]) begin
      acc_re_d   = acc_re_q + re_term;
      acc_im_d   = acc_im_q + im_term;
      proc_cnt_d = proc_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (32'(i_log2_samples) > MAX_LOG2) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d    = ACCUM;
            l_d        = i_log2_samples;
            mode_d     = i_mode;
            rx_cnt_d   = '0;
            proc_cnt_d = '0;
            acc_re_d   = '0;
            acc_im_d   = '0;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
          if (rx_cnt_d == win) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (proc_cnt_q == win) state_d = DIVIDE;
      end
      DIVIDE: begin
        o_data_d  = {OW'(rnd_re >>> l_q), OW'(rnd_im >>> l_q)};
        o_valid_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (i_ready) begin
          o_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      l_q        <= '0;
      mode_q     <= 1'b0;
      rx_cnt_q   <= '0;
      proc_cnt_q <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      cfg_err_q  <= 1'b0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      mode_q     <= mode_d;
      rx_cnt_q   <= rx_cnt_d;
      proc_cnt_q <= proc_cnt_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      cfg_err_q  <= cfg_err_d;
      vld_q      <= vld_d;
    end
  end

  // NOTE: product stages carry no reset; the valid shift register alone decides what is consumed.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < MUL_LAT; i++) begin
      aa_q[i] <= aa_d[i];
      bb_q[i] <= bb_d[i];
      ab_q[i] <= ab_d[i];
    end
  end

endmodule
